// File: rtl/lane_pkg.sv
// Shared lane definitions: state encoding and the saturating green-length scale.
// Used by lane_ctrl, the arbiter and the testbench.
package lane_pkg;

  typedef enum logic [1:0] {
    ST_RED    = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_CLEAR  = 2'd3
  } lane_state_e;

  // Saturates to max_g before any caller truncation; floor of one cycle.
  // 32-bit arithmetic covers TIMER_W+DENS_W+1 for any practical widths.
  function automatic int unsigned green_len(input int unsigned base,
                                            input int unsigned step,
                                            input int unsigned max_g,
                                            input int unsigned dens);
    int unsigned raw;
    raw = base + dens * step;
    if (raw > max_g) raw = max_g;
    if (raw == 0)    raw = 1;
    return raw;
  endfunction

endpackage

// File: rtl/lane_ctrl_if.sv
// Arbiter <-> lane controller bundle: grant/density/preempt in, lamps and status out.
interface lane_ctrl_if #(
  parameter int unsigned DENS_W  = 2,
  parameter int unsigned TIMER_W = 8
);
  logic               grant;
  logic [DENS_W-1:0]  density;
  logic               preempt;
  logic               green;
  logic               yellow;
  logic               red;
  logic               busy;
  logic               done;
  logic [TIMER_W-1:0] remaining;

  modport master (
    output grant, density, preempt,
    input  green, yellow, red, busy, done, remaining
  );

  modport slave (
    input  grant, density, preempt,
    output green, yellow, red, busy, done, remaining
  );
endinterface

// File: rtl/lane_timer.sv
// Loadable down-counter; holds at zero, load wins over decrement.
module lane_timer #(
  parameter int unsigned TIMER_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               dec,
  output logic [TIMER_W-1:0] value,
  output logic               zero
);

  logic [TIMER_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load)                      value_d = load_val;
    else if (dec && value_q != '0) value_d = value_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) value_q <= '0;
    else       value_q <= value_d;
  end

  assign value = value_q;
  assign zero  = (value_q == '0);

endmodule

// File: rtl/lane_ctrl.sv
// Single-lane signal controller: grant starts GREEN -> YELLOW -> CLEAR -> RED,
// with density-scaled green, emergency pre-emption and a done pulse.
module lane_ctrl
  import lane_pkg::*;
#(
  parameter int unsigned DENS_W      = 2,
  parameter int unsigned TIMER_W     = 8,
  parameter int unsigned GREEN_BASE  = 10,
  parameter int unsigned GREEN_STEP  = 5,
  parameter int unsigned MAX_GREEN   = 60,
  parameter int unsigned YELLOW_TIME = 3,
  parameter int unsigned CLEAR_TIME  = 2
) (
  input  logic        clk,
  input  logic        reset,
  lane_ctrl_if.slave  bus
);

  localparam int unsigned GW = TIMER_W + DENS_W + 1;
  localparam logic [TIMER_W-1:0] Y_LOAD = TIMER_W'(YELLOW_TIME - 1);
  localparam logic [TIMER_W-1:0] C_LOAD =
    (CLEAR_TIME > 0) ? TIMER_W'(CLEAR_TIME - 1) : '0;

  lane_state_e        state_q, state_d;
  logic               done_q, done_d;
  logic               t_load, t_dec, t_zero;
  logic [TIMER_W-1:0] t_load_val, t_value;
  logic [GW-1:0]      g_len;
  logic [TIMER_W-1:0] g_load;

  // Already saturated to MAX_GREEN, so narrowing to the timer is safe.
  assign g_len  = GW'(green_len(GREEN_BASE, GREEN_STEP, MAX_GREEN, 32'(bus.density)));
  assign g_load = TIMER_W'(g_len - 1'b1);

  lane_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_load_val),
    .dec      (t_dec),
    .value    (t_value),
    .zero     (t_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RED;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    t_load     = 1'b0;
    t_load_val = '0;
    t_dec      = 1'b0;
    unique case (state_q)
      ST_RED: begin
        if (bus.grant && !bus.preempt) begin
          state_d    = ST_GREEN;
          t_load     = 1'b1;
          t_load_val = g_load;
        end
      end
      ST_GREEN: begin
        if (t_zero || bus.preempt) begin
          state_d    = ST_YELLOW;
          t_load     = 1'b1;
          t_load_val = Y_LOAD;
        end else begin
          t_dec = 1'b1;
        end
      end
      ST_YELLOW: begin
        if (t_zero) begin
          if (CLEAR_TIME > 0) begin
            state_d    = ST_CLEAR;
            t_load     = 1'b1;
            t_load_val = C_LOAD;
          end else begin
            state_d = ST_RED;
          end
        end else begin
          t_dec = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (t_zero) state_d = ST_RED;
        else        t_dec   = 1'b1;
      end
      default: state_d = ST_RED;
    endcase
    done_d = (state_q != ST_RED) && (state_d == ST_RED);
  end

  always_comb begin
    bus.green     = (state_q == ST_GREEN);
    bus.yellow    = (state_q == ST_YELLOW);
    bus.red       = (state_q == ST_RED) || (state_q == ST_CLEAR);
    bus.busy      = (state_q != ST_RED);
    bus.done      = done_q;
    bus.remaining = (state_q == ST_RED) ? '0 : t_value;
  end

endmodule

// File: tb/tb_lane_ctrl.sv
// Directed bench for lane_ctrl: four parameterisations share one stimulus set.
module tb_lane_ctrl;
  import lane_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       grant;
  logic [1:0] density;
  logic       preempt;
  int         errs = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  // 0: defaults  1: base 50 step 10  2: base 0 step 0  3: CLEAR_TIME 0
  lane_ctrl_if #(.DENS_W(2), .TIMER_W(8)) if0 ();
  lane_ctrl_if #(.DENS_W(2), .TIMER_W(8)) if1 ();
  lane_ctrl_if #(.DENS_W(2), .TIMER_W(8)) if2 ();
  lane_ctrl_if #(.DENS_W(2), .TIMER_W(8)) if3 ();

  assign if0.grant = grant; assign if0.density = density; assign if0.preempt = preempt;
  assign if1.grant = grant; assign if1.density = density; assign if1.preempt = preempt;
  assign if2.grant = grant; assign if2.density = density; assign if2.preempt = preempt;
  assign if3.grant = grant; assign if3.density = density; assign if3.preempt = preempt;

  lane_ctrl u0 (.clk(clk), .reset(reset), .bus(if0));
  lane_ctrl #(.GREEN_BASE(50), .GREEN_STEP(10)) u1 (.clk(clk), .reset(reset), .bus(if1));
  lane_ctrl #(.GREEN_BASE(0),  .GREEN_STEP(0))  u2 (.clk(clk), .reset(reset), .bus(if2));
  lane_ctrl #(.CLEAR_TIME(0))                   u3 (.clk(clk), .reset(reset), .bus(if3));

  logic [3:0] g_a, y_a, r_a, b_a, d_a;
  logic [7:0] rem_a [4];

  assign g_a = {if3.green,  if2.green,  if1.green,  if0.green};
  assign y_a = {if3.yellow, if2.yellow, if1.yellow, if0.yellow};
  assign r_a = {if3.red,    if2.red,    if1.red,    if0.red};
  assign b_a = {if3.busy,   if2.busy,   if1.busy,   if0.busy};
  assign d_a = {if3.done,   if2.done,   if1.done,   if0.done};
  assign rem_a[0] = if0.remaining;
  assign rem_a[1] = if1.remaining;
  assign rem_a[2] = if2.remaining;
  assign rem_a[3] = if3.remaining;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; grant = 1'b0; preempt = 1'b0; density = 2'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic count_lamp(input int k, input int which, output int n);
    n = 0;
    while (n < 300) begin
      if (which == 0 && !g_a[k]) break;
      if (which == 1 && !y_a[k]) break;
      if (which == 2 && !(r_a[k] && b_a[k])) break;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_seq(input int k, input bit hold, output int gn, output int yn,
                         output int cn, output int rem0);
    grant = 1'b1;
    @(negedge clk);
    if (!hold) grant = 1'b0;
    rem0 = rem_a[k];
    count_lamp(k, 0, gn);
    count_lamp(k, 1, yn);
    count_lamp(k, 2, cn);
  endtask

  int gn, yn, cn, rem0;

  initial begin
    do_reset();
    chk("rst_red",    r_a[0], 1);
    chk("rst_green",  g_a[0], 0);
    chk("rst_yellow", y_a[0], 0);
    chk("rst_busy",   b_a[0], 0);
    chk("rst_done",   d_a[0], 0);
    chk("rst_rem",    rem_a[0], 0);

    density = 2'd2;
    run_seq(0, 1'b0, gn, yn, cn, rem0);
    chk("d2_rem_first", rem0, 19);
    chk("d2_green", gn, 20);
    chk("d2_yellow", yn, 3);
    chk("d2_clear", cn, 2);
    chk("d2_done", d_a[0], 1);
    chk("d2_done_red", r_a[0], 1);
    @(negedge clk);
    chk("d2_done_once", d_a[0], 0);

    do_reset(); density = 2'd3;
    run_seq(1, 1'b0, gn, yn, cn, rem0);
    chk("sat_rem_first", rem0, 59);
    chk("sat_green", gn, 60);
    chk("sat_done", d_a[1], 1);

    do_reset(); density = 2'd3;
    run_seq(2, 1'b0, gn, yn, cn, rem0);
    chk("floor_green", gn, 1);
    chk("floor_yellow", yn, 3);

    do_reset(); density = 2'd2;
    run_seq(3, 1'b0, gn, yn, cn, rem0);
    chk("noclr_green", gn, 20);
    chk("noclr_yellow", yn, 3);
    chk("noclr_clear", cn, 0);
    chk("noclr_done", d_a[3], 1);
    @(negedge clk);
    chk("noclr_done_once", d_a[3], 0);

    // Pre-empt at the 5th green cycle, held high across yellow.
    do_reset(); density = 2'd2;
    grant = 1'b1; @(negedge clk); grant = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_still_green", g_a[0], 1);
    preempt = 1'b1;
    @(negedge clk);
    chk("pre_yellow_now", y_a[0], 1);
    chk("pre_rem_yellow", rem_a[0], 2);
    count_lamp(0, 1, yn);
    chk("pre_yellow_len", yn, 3);
    preempt = 1'b0;
    count_lamp(0, 2, cn);
    chk("pre_clear_len", cn, 2);
    chk("pre_done", d_a[0], 1);

    // Continuous grant: re-grant taken in the done cycle.
    do_reset(); density = 2'd2;
    run_seq(0, 1'b1, gn, yn, cn, rem0);
    chk("hold_green", gn, 20);
    chk("hold_done", d_a[0], 1);
    @(negedge clk);
    chk("hold_regreen", g_a[0], 1);
    chk("hold_rem", rem_a[0], 19);
    grant = 1'b0;

    do_reset();
    grant = 1'b1; preempt = 1'b1;
    repeat (3) @(negedge clk);
    chk("gp_red", r_a[0], 1);
    chk("gp_busy", b_a[0], 0);
    grant = 1'b0; preempt = 1'b0;

    // Reset mid-green, then a fresh full-length sequence.
    do_reset(); density = 2'd2;
    grant = 1'b1; @(negedge clk); grant = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_red", r_a[0], 1);
    chk("mrst_busy", b_a[0], 0);
    chk("mrst_done", d_a[0], 0);
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_no_done", d_a[0], 0);
    run_seq(0, 1'b0, gn, yn, cn, rem0);
    chk("mrst_green", gn, 20);
    chk("mrst_done2", d_a[0], 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
